logic_unit_arbiter: RTL and testbench

Shares one registered W-bit logic unit between two requesters using round-robin arbitration. Each requester presents an opcode and two operands and holds a request. The arbiter grants one requester, latches its operands and computes the result. It then returns the result with a one-cycle done pulse to the granted requester. The block sits between the control FSMs of the lab datapath and the single shared logic unit.

---
 rtl/logic_unit_arbiter_pkg.sv | 17 +
 rtl/logic_unit_arbiter_if.sv | 36 +++
 rtl/logic_unit_arbiter_lu.sv | 26 ++
 rtl/logic_unit_arbiter.sv | 115 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Purpose: shared opcode and FSM state encodings for the logic unit arbiter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package logic_unit_pkg;

    // Opcodes, applied bitwise across the operand width
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Purpose: two-requester request/grant/done bundle between lab control FSMs and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse; the arbiter never stalls done.
interface logic_unit_arbiter_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             req0;
    logic [1:0]       op0;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic             req1;
    logic [1:0]       op1;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [W-1:0]     result;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // Requester side: drives requests and operands, observes grants and results
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  gnt0, gnt1, done0, done1, result, busy, cnt0, cnt1
    );

    // Arbiter side
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output gnt0, gnt1, done0, done1, result, busy, cnt0, cnt1
    );
endinterface

// File: rtl/logic_unit_arbiter_lu.sv
// Purpose: combinational W-bit logic function (and/or/xor/not) selected by a 2-bit opcode.
// Latency: 0 cycles (pure combinational; the caller registers the output).
// Backpressure: none.
module logic_unit_w
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Select the bitwise operation; NOT ignores b
    always_comb begin
        y = ~a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~a;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Purpose: round-robin share of one registered logic unit between two requesters (LU_OP_COUNT_EN adds op counters).
// Latency: done pulses 2 cycles after req is sampled in IDLE; one op per 3 cycles.
// Backpressure: req held until done; requests are ignored outside IDLE.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_unit_arbiter_if.slave   bus
);

    logic [1:0]   state_q;
    logic         rr_last_q;
    logic [1:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] result_q;
    logic         gnt0_q;
    logic         gnt1_q;
    logic         done0_q;
    logic         done1_q;
    logic [W-1:0] lu_y;
    logic         any_req;
    logic         pick1;

    // Winner selection: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick1   = bus.req1 & (~bus.req0 | ~rr_last_q);
    end

    logic_unit_w #(.W(W)) u_lu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (lu_y)
    );

    // Control FSM plus operand/result registers; gnt flags double as the record of the winner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        op_q    <= pick1 ? bus.op1 : bus.op0;
                        a_q     <= pick1 ? bus.a1  : bus.a0;
                        b_q     <= pick1 ? bus.b1  : bus.b0;
                        gnt0_q  <= ~pick1;
                        gnt1_q  <= pick1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= lu_y;
                    done0_q  <= gnt0_q;
                    done1_q  <= gnt1_q;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    done0_q   <= 1'b0;
                    done1_q   <= 1'b0;
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    rr_last_q <= gnt1_q;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LU_OP_COUNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating completed-op counters, bumped as the winner leaves DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == ST_DONE) begin
            if (gnt0_q && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_W'(1);
            if (gnt1_q && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`else
    assign bus.cnt0 = '0;
    assign bus.cnt1 = '0;
`endif

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Purpose: self-checking bench for logic_unit_arbiter with a result scoreboard (honours LU_OP_COUNT_EN).
// Latency: expects done 2 cycles after req is sampled, pulses 3 cycles apart under contention.
// Backpressure: requesters hold req until done, then drop it.
module tb_logic_unit_arbiter;

`ifdef LU_OP_COUNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit         exp_who[$];
    logic [7:0] exp_res[$];
    int         exp_cnt0 = 0;
    int         exp_cnt1 = 0;
    bit         prev_done = 1'b0;

    logic_unit_arbiter_if #(.W(8), .CNT_W(CNT_W)) bus ();

    logic_unit_arbiter #(.W(8), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest expected owner/result
    always @(negedge clk) begin
        if (rst_n && (bus.done0 || bus.done1)) begin
            if (exp_who.size() == 0) begin
                check_eq("spurious_done", {30'd0, bus.done1, bus.done0}, 32'd0);
            end else begin
                bit         w;
                logic [7:0] r;
                w = exp_who.pop_front();
                r = exp_res.pop_front();
                check_eq("done_owner", {31'd0, bus.done1}, {31'd0, w});
                check_eq("result", {24'd0, bus.result}, {24'd0, r});
                check_eq("done_excl", {31'd0, bus.done0 & bus.done1}, 32'd0);
                check_eq("gnt_excl", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
                check_eq("done_width", {31'd0, prev_done}, 32'd0);
`ifdef LU_OP_COUNT_EN
                if (!w && exp_cnt0 < CNT_MAX) exp_cnt0++;
                if (w && exp_cnt1 < CNT_MAX) exp_cnt1++;
`endif
            end
        end
        prev_done = bus.done0 | bus.done1;
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check_eq({tag, "_gnt"}, {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check_eq({tag, "_cnt0"}, 32'(bus.cnt0), 32'(exp_cnt0));
        check_eq({tag, "_cnt1"}, 32'(bus.cnt1), 32'(exp_cnt1));
    endtask

    task automatic do_reset(input int edges);
        rst_n = 1'b0;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_who.delete();
        exp_res.delete();
    endtask

    // One solo operation; called at a negedge, returns at a negedge back in IDLE
    task automatic run_op(input bit who, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        bit seen;
        if (!who) begin
            bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        end else begin
            bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
        end
        exp_who.push_back(who);
        exp_res.push_back(ref_op(op, a, b));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_eq("gnt_exec", {31'd0, who ? bus.gnt1 : bus.gnt0}, 32'd1);
                // operands only need to be stable up to the EXEC edge
                if (!who) begin bus.a0 = ~a; bus.b0 = ~b; end
                else begin bus.a1 = ~a; bus.b1 = ~b; end
            end
            if (bus.done0 || bus.done1) seen = 1'b1;
        end
        check_eq("latency", n, 2);
        check_eq("gnt_done", {31'd0, who ? bus.gnt1 : bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("post_op");
    endtask

    initial begin
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 8'hF0; bus.b0 = 8'h3C;
        bus.req1 = 1'b0; bus.op1 = 2'b00; bus.a1 = 8'h00; bus.b1 = 8'h00;

        // Reset with req0 held
        do_reset(2);
        check_eq("rst_out", {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
        check_eq("rst_result", {24'd0, bus.result}, 32'd0);
        check_idle("rst");
        rst_n = 1'b1;

        // Single op from requester 0, granted on the first sampled edge
        run_op(1'b0, 2'b00, 8'hF0, 8'h3C);

        // All remaining opcodes through requester 1
        run_op(1'b1, 2'b01, 8'hA5, 8'h0F);
        run_op(1'b1, 2'b10, 8'hA5, 8'h0F);
        run_op(1'b1, 2'b11, 8'hA5, 8'h0F);

        // Contention: both requests held for four ops, grants must alternate 0,1,0,1
        begin
            int last_done;
            int n;
            bus.op0 = 2'b10; bus.a0 = 8'h3C; bus.b0 = 8'hFF;
            bus.op1 = 2'b00; bus.a1 = 8'h77; bus.b1 = 8'h1E;
            for (int k = 0; k < 4; k++) begin
                exp_who.push_back(k[0]);
                exp_res.push_back(k[0] ? (8'h77 & 8'h1E) : (8'h3C ^ 8'hFF));
            end
            bus.req0 = 1'b1;
            bus.req1 = 1'b1;
            last_done = 0;
            for (int k = 0; k < 4; k++) begin
                n = 0;
                do begin
                    @(posedge clk);
                    @(negedge clk);
                    n++;
                end while (!(bus.done0 || bus.done1) && n < 10);
                check_eq("tie_owner", {31'd0, bus.done1}, {31'd0, k[0]});
                if (k > 0) check_eq("tie_spacing", cyc - last_done, 3);
                last_done = cyc;
            end
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_idle("tie_end");
        end

        // Requester 0 served last, so a reset must be what restores its tie priority
        run_op(1'b0, 2'b01, 8'h12, 8'h40);
        bus.op1 = 2'b11; bus.a1 = 8'h0F; bus.b1 = 8'h00; bus.req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_in_exec", {31'd0, bus.gnt1}, 32'd1);
        bus.req1 = 1'b0;
        do_reset(1);
        check_eq("abort_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        check_eq("abort_result", {24'd0, bus.result}, 32'd0);
        check_idle("abort");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        begin
            int n;
            bus.op0 = 2'b00; bus.a0 = 8'hCC; bus.b0 = 8'hAA;
            bus.op1 = 2'b01; bus.a1 = 8'h01; bus.b1 = 8'h02;
            exp_who.push_back(1'b0);
            exp_res.push_back(8'h88);
            bus.req0 = 1'b1;
            bus.req1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("post_rst_tie", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
            n = 0;
            while (!(bus.done0 || bus.done1) && n < 8) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            check_eq("post_rst_lat", n, 1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end

        // Counter run from a clean reset: five ops from requester 0
        do_reset(2);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_op(1'b0, k[1:0], 8'h5A + 8'(k), 8'hC3);
        end
`ifdef LU_OP_COUNT_EN
        check_eq("cnt0_sat", 32'(bus.cnt0), 32'd3);
`else
        check_eq("cnt0_off", 32'(bus.cnt0), 32'd0);
`endif
        check_eq("cnt1_idle", 32'(bus.cnt1), 32'd0);
        check_eq("sb_empty", exp_who.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
